// File: rtl/mem2d_pkg.sv
// Shared widths, memory geometry and scan FSM encoding for the 2-D memory reader.
package mem2d_pkg;

  localparam int XW = 6;
  localparam int YW = 5;
  localparam int DW = 8;

  localparam int MEM_COLS  = 1 << XW;
  localparam int MEM_ROWS  = 1 << YW;
  localparam int MEM_BYTES = MEM_COLS * MEM_ROWS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mem2d_out_stage.sv
// Registered valid/ready output slot: loads a new byte with its row/frame markers,
// holds it unchanged under backpressure, and empties on handshake or flush.
module mem2d_out_stage #(
  parameter int DW = mem2d_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_eol,
  input  logic          load_last,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_eol,
  output logic          m_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_eol   <= 1'b0;
      m_last  <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_eol   <= load_eol;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      // payload fields are left as-is; only the valid flag drops
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem2d_scan_reader.sv
// Walks a programmable window of the 2-D memory in row-major order and streams
// the read bytes out over valid/ready with end-of-row and end-of-window markers.
module mem2d_scan_reader #(
  parameter int XW = mem2d_pkg::XW,
  parameter int YW = mem2d_pkg::YW,
  parameter int DW = mem2d_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w_m1,
  input  logic [YW-1:0] h_m1,
  output logic [XW-1:0] mem_addr_x,
  output logic [YW-1:0] mem_addr_y,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_eol,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  import mem2d_pkg::*;

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  state_t        state, state_nxt;
  logic [XW-1:0] x0_r, w_r, cx;
  logic [YW-1:0] y0_r, h_r, cy;
  logic          adv, row_end, win_end;
  logic          start_ok, capture, final_hs, flush;

  assign adv      = !m_valid || m_ready;
  assign row_end  = (cx == w_r);
  assign win_end  = row_end && (cy == h_r);
  assign start_ok = (state == IDLE) && start && !abort;
  assign capture  = (state == SCAN) && adv && !abort;
  assign final_hs = (state == DRAIN) && m_valid && m_ready && m_last && !abort;
  assign flush    = abort && (state != IDLE);

  assign busy   = (state != IDLE);
  assign mem_wr = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = SCAN;
      end
      SCAN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (capture && win_end) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || final_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The address register always points at the byte the counters select, so the
  // memory's combinational data is ready for capture on the next advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r       <= '0;
      y0_r       <= '0;
      w_r        <= '0;
      h_r        <= '0;
      cx         <= '0;
      cy         <= '0;
      mem_addr_x <= '0;
      mem_addr_y <= '0;
    end else if (start_ok) begin
      x0_r       <= x0;
      y0_r       <= y0;
      w_r        <= w_m1;
      h_r        <= h_m1;
      cx         <= '0;
      cy         <= '0;
      mem_addr_x <= x0;
      mem_addr_y <= y0;
    end else if (capture) begin
      if (row_end) begin
        cx         <= '0;
        cy         <= cy + Y_ONE;
        mem_addr_x <= x0_r;
        mem_addr_y <= y0_r + cy + Y_ONE;
      end else begin
        cx         <= cx + X_ONE;
        mem_addr_x <= x0_r + cx + X_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= final_hs;
    end
  end

  mem2d_out_stage #(
    .DW (DW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (capture),
    .load_data (mem_data),
    .load_eol  (row_end),
    .load_last (win_end),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_eol     (m_eol),
    .m_last    (m_last)
  );

endmodule

// File: tb/tb_mem2d_scan_reader.sv
// Bench for mem2d_scan_reader with a behavioural 64x32 memory holding (x*4+y) mod 256.
module tb_mem2d_scan_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       m_ready = 1'b0;
  logic [5:0] x0 = '0;
  logic [5:0] w_m1 = '0;
  logic [4:0] y0 = '0;
  logic [4:0] h_m1 = '0;
  logic [5:0] mem_addr_x;
  logic [4:0] mem_addr_y;
  logic       mem_wr;
  logic [7:0] mem_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_eol;
  logic       m_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:31][0:63];
  assign mem_data = mem[mem_addr_y][mem_addr_x];

  always #5 clk = ~clk;

  mem2d_scan_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .x0         (x0),
    .y0         (y0),
    .w_m1       (w_m1),
    .h_m1       (h_m1),
    .mem_addr_x (mem_addr_x),
    .mem_addr_y (mem_addr_y),
    .mem_wr     (mem_wr),
    .mem_data   (mem_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_eol      (m_eol),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0] ax;
    logic [4:0] ay;
    logic [7:0] data;
    logic       eol;
    logic       last;
  } vec_t;

  vec_t wrap_tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {eol, last, data} of byte i of a W x H window at (sx0, sy0)
  function automatic logic [9:0] exp_byte(int sx0, int sy0, int w, int h, int i);
    int cx, cy, x, y;
    cx = i % w;
    cy = i / w;
    x  = (sx0 + cx) % 64;
    y  = (sy0 + cy) % 32;
    return {1'(cx == w - 1), 1'(i == w * h - 1), 8'((x * 4 + y) % 256)};
  endfunction

  task automatic do_start(input logic [5:0] sx0, input logic [4:0] sy0,
                          input logic [5:0] sw, input logic [4:0] sh);
    @(negedge clk);
    x0 = sx0; y0 = sy0; w_m1 = sw; h_m1 = sh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input logic [5:0] sx0, input logic [4:0] sy0,
                          input logic [5:0] sw, input logic [4:0] sh,
                          input bit rnd, input string tag);
    int w, h, total, got, c;
    logic prev_stall;
    logic [7:0] pd;
    logic pe, pl;
    logic [5:0] pax;
    logic [4:0] pay;
    w = int'(sw) + 1;
    h = int'(sh) + 1;
    total = w * h;
    got = 0;
    c = 0;
    prev_stall = 1'b0;
    pd = '0; pe = 1'b0; pl = 1'b0; pax = '0; pay = '0;
    do_start(sx0, sy0, sw, sh);
    chk({tag, " busy_at_start"}, 32'(busy), 32'd1);
    chk({tag, " valid_at_start"}, 32'(m_valid), 32'd0);
    while (got < total && c < 8 * total + 20) begin
      if (prev_stall) begin
        chk({tag, " hold_out"}, {m_valid, m_eol, m_last, m_data}, {1'b1, pe, pl, pd});
        chk({tag, " hold_addr"}, {mem_addr_y, mem_addr_x}, {pay, pax});
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        chk({tag, " byte"}, {m_eol, m_last, m_data}, exp_byte(sx0, sy0, w, h, got));
        chk({tag, " busy_mid"}, 32'(busy), 32'd1);
        if (!rnd) chk({tag, " no_bubble"}, c, got + 1);
        got++;
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data; pe = m_eol; pl = m_last; pax = mem_addr_x; pay = mem_addr_y;
      @(negedge clk);
      c++;
    end
    m_ready = 1'b0;
    chk({tag, " byte_count"}, got, total);
    chk({tag, " end_flags"}, {done, busy, m_valid}, 3'b100);
    if (!rnd) chk({tag, " cycles"}, c, total + 1);
    @(negedge clk);
    chk({tag, " done_width"}, {done, busy, m_valid}, 3'b000);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        mem[y][x] = 8'((x * 4 + y) % 256);

    wrap_tab[0] = '{6'd62, 5'd31, 8'h17, 1'b0, 1'b0};
    wrap_tab[1] = '{6'd63, 5'd31, 8'h1B, 1'b0, 1'b0};
    wrap_tab[2] = '{6'd0,  5'd31, 8'h1F, 1'b0, 1'b0};
    wrap_tab[3] = '{6'd1,  5'd31, 8'h23, 1'b1, 1'b0};
    wrap_tab[4] = '{6'd62, 5'd0,  8'hF8, 1'b0, 1'b0};
    wrap_tab[5] = '{6'd63, 5'd0,  8'hFC, 1'b0, 1'b0};
    wrap_tab[6] = '{6'd0,  5'd0,  8'h00, 1'b0, 1'b0};
    wrap_tab[7] = '{6'd1,  5'd0,  8'h04, 1'b1, 1'b1};

    // reset values
    @(negedge clk);
    chk("reset_outputs",
        {mem_addr_x, mem_addr_y, m_valid, m_data, m_eol, m_last, busy, done, mem_wr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {m_valid, busy, done, mem_wr}, 4'b0000);

    // wrap window: address before capture, output after capture
    do_start(6'd62, 5'd31, 6'd3, 5'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("wrap_addr", {mem_addr_x, mem_addr_y}, {wrap_tab[i].ax, wrap_tab[i].ay});
      @(negedge clk);
      chk("wrap_out", {m_valid, m_eol, m_last, m_data},
          {1'b1, wrap_tab[i].eol, wrap_tab[i].last, wrap_tab[i].data});
    end
    @(negedge clk);
    chk("wrap_done", {done, busy, m_valid}, 3'b100);
    m_ready = 1'b0;
    @(negedge clk);
    chk("wrap_done_width", 32'(done), 32'd0);

    run_scan(6'd0, 5'd0, 6'd63, 5'd31, 1'b0, "full");
    run_scan(6'd7, 5'd2, 6'd3, 5'd1, 1'b1, "bp");
    run_scan(6'd61, 5'd30, 6'd3, 5'd1, 1'b1, "bp_wrap");
    run_scan(6'd20, 5'd9, 6'd0, 5'd0, 1'b0, "single");
    chk("mem_wr_low", 32'(mem_wr), 32'd0);

    // second start mid-scan must be ignored
    do_start(6'd0, 5'd0, 6'd3, 5'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin start = 1'b1; x0 = 6'd30; y0 = 5'd7; end
      if (i == 3) start = 1'b0;
      @(negedge clk);
      chk("busy_start_byte", {m_valid, m_eol, m_last, m_data},
          {1'b1, exp_byte(0, 0, 4, 2, i)});
    end
    @(negedge clk);
    chk("busy_start_done", {done, busy, m_valid}, 3'b100);
    @(negedge clk);
    chk("busy_start_no_rescan", {done, busy, m_valid}, 3'b000);
    m_ready = 1'b0;

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1; x0 = 6'd4; y0 = 5'd4; w_m1 = 6'd1; h_m1 = 5'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, m_valid, done}, 3'b000);
    repeat (3) @(negedge clk);
    chk("start_abort_quiet", {busy, m_valid, done}, 3'b000);

    // abort after 5 bytes of a 16-byte window
    do_start(6'd5, 5'd5, 6'd3, 5'd3);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_byte", {m_valid, m_eol, m_last, m_data}, {1'b1, exp_byte(5, 5, 4, 4, i)});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_next", {m_valid, busy, done}, 3'b000);
    @(negedge clk);
    chk("abort_no_done", {m_valid, busy, done}, 3'b000);
    m_ready = 1'b0;

    // reset mid-scan
    do_start(6'd0, 5'd0, 6'd63, 5'd31);
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_reset_active", {busy, m_valid}, 2'b11);
    rst = 1'b1;
    #1;
    chk("reset_mid_scan",
        {mem_addr_x, mem_addr_y, m_valid, m_data, m_eol, m_last, busy, done, mem_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {busy, m_valid, done}, 3'b000);

    run_scan(6'd2, 5'd3, 6'd3, 5'd1, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem2d_scan_reader.md
Name: mem2d_scan_reader

Overview:
- Read-side initiator for the 64x32-byte two-dimensional memory.
- Walks a programmable rectangular window in row-major order and drives the memory's x/y address with write held low.
- Captures the memory's combinational read data into a registered output stage.
- Streams the bytes out over a valid/ready interface with row and frame markers, for downstream display and transmit blocks.

Parameters:
- XW, 6, x-address width (memory is 2^XW columns)
- YW, 5, y-address width (memory is 2^YW rows)
- DW, 8, data width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE
- abort  in  1  synchronous cancel of the current scan
- x0  in  XW  window origin column, sampled at start
- y0  in  YW  window origin row, sampled at start
- w_m1  in  XW  window width minus 1, sampled at start
- h_m1  in  YW  window height minus 1, sampled at start
- mem_addr_x  out  XW  memory column address
- mem_addr_y  out  YW  memory row address
- mem_wr  out  1  memory write enable, constant 0
- mem_data  in  DW  memory read data, combinational from the address
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accept
- m_data  out  DW  output byte
- m_eol  out  1  byte is the last of its row
- m_last  out  1  byte is the last of the window
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (async, rst=1): state IDLE, counters 0, and all outputs 0 (mem_addr_x, mem_addr_y, m_valid, m_data, m_eol, m_last, busy, done). mem_wr is always 0.
- States: IDLE, SCAN, DRAIN.
- IDLE -> SCAN when start=1 at an edge:
  - Latch x0, y0, w_m1, h_m1; clear column counter cx and row counter cy; set busy=1.
  - start while busy=1 is ignored; latched parameters do not change.
- Addressing:
  - mem_addr_x = (x0 + cx) mod 2^XW; mem_addr_y = (y0 + cy) mod 2^YW, registered from the counters.
  - The window wraps at the memory edges; there is no clamping.
- SCAN, advance condition adv = (!m_valid || m_ready). When adv=1 at an edge:
  - m_data <= mem_data; m_valid <= 1.
  - m_eol <= (cx == w_m1); m_last <= (cx == w_m1 && cy == h_m1).
  - Step cx; on cx == w_m1, reset cx to 0 and step cy.
  - After capturing the final byte, go to DRAIN.
- SCAN, adv=0: the address, counters and output register hold.
- Output stage:
  - If m_valid && m_ready and no new capture, m_valid <= 0.
  - m_data, m_eol and m_last are stable while m_valid=1 and m_ready=0.
- DRAIN: when the final byte is handshaked (m_valid && m_ready && m_last):
  - m_valid <= 0, busy <= 0, state IDLE.
  - done=1 for exactly the next cycle.
- Latency:
  - Start accepted at edge k; first byte m_valid=1 after edge k+1.
  - With m_ready held 1, one byte per cycle and no bubbles, including across row boundaries.
  - A W x H window completes in W*H+1 cycles from start; done pulses the cycle after the last handshake.
- Boundaries:
  - w_m1=0, h_m1=0 gives a single byte with m_eol=m_last=1.
  - Maximum window is 64x32 = 2048 bytes.
- abort=1 in SCAN or DRAIN: next edge goes to IDLE, m_valid=0, busy=0, done stays 0. abort in IDLE has no effect.
- start and abort in the same cycle while IDLE: abort wins and no scan starts.
- rst asserted mid-scan: immediate return to reset values; the partial stream is discarded.

Decomposition:
- Package mem2d_pkg holds XW, YW, DW, the state encoding (IDLE, SCAN, DRAIN) and memory dimension constants.
- One sub-module is natural: mem2d_out_stage, the valid/ready output register with hold-under-backpressure.
- Counters and the FSM stay in the top module.
- The bench pairs the DUT with a behavioural 64x32 memory preloaded with value (x*4+y) mod 256.

Test Plan:
- Full frame, m_ready=1: x0=0, y0=0, w_m1=63, h_m1=31 -> 2048 bytes on consecutive cycles matching (x*4+y) mod 256 in row-major order; m_eol every 64th byte; m_last only on byte 2048; done one cycle later.
- Wrap window: x0=62, y0=31, w_m1=3, h_m1=1 -> addresses (62,31),(63,31),(0,31),(1,31),(62,0),(63,0),(0,0),(1,0); m_eol on bytes 4 and 8; m_last on byte 8.
- Backpressure: 4x2 window with m_ready toggling randomly -> same 8 bytes in order, none dropped or duplicated, m_data stable while stalled, mem address frozen while adv=0.
- Single byte: w_m1=0, h_m1=0 -> one byte with m_eol=m_last=1; busy high 2 cycles; done pulse 1 cycle.
- Start while busy: second start mid-scan with different x0 -> ignored; output follows the first window only.
- Abort and reset: abort after 5 bytes of a 16-byte window -> m_valid=0 and busy=0 next cycle, no done. rst mid-scan -> all outputs 0 immediately. A new start afterwards -> clean scan from byte 0.
